// File: rtl/run_ctrl_if.sv
// Run-control handshake bundle: bench/processor-facing request, halt and
// status signals shared between the run controller and its environment.
interface run_ctrl_if #(
  parameter int unsigned CW = 16
);
  logic          req;
  logic          core_halt;
  logic          core_rst;
  logic          core_en;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycle_count;
  logic [1:0]    state;

  // Environment side: issues run requests and reports processor halt.
  modport master (
    output req,
    output core_halt,
    input  core_rst,
    input  core_en,
    input  done,
    input  timeout,
    input  cycle_count,
    input  state
  );

  // Controller side.
  modport slave (
    input  req,
    input  core_halt,
    output core_rst,
    output core_en,
    output done,
    output timeout,
    output cycle_count,
    output state
  );
endinterface

// File: rtl/run_ctrl.sv
// Run controller: sequences a processor through reset, a bounded run and a
// done handshake. A run starts on req, holds the core in reset for RST_CYC
// cycles, counts enabled run cycles until core_halt or the MAX_CYC limit,
// then parks in DONE (core frozen) until req is released.
module run_ctrl #(
  parameter int unsigned   RST_CYC = 2,        // 1..15
  parameter int unsigned   CW      = 16,
  parameter logic [CW-1:0] MAX_CYC = 16'hFFFF  // 1..2^CW-1
) (
  input logic       clk,
  input logic       reset,
  run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RESET_CORE = 2'd1,
    RUN        = 2'd2,
    DONE       = 2'd3
  } state_e;

  // Hold counter counts down to zero, so loading RST_CYC-1 yields exactly
  // RST_CYC cycles in RESET_CORE.
  localparam logic [3:0] RST_LOAD = 4'(RST_CYC - 1);

  state_e        state_q,    state_d;
  logic [3:0]    rst_cnt_q,  rst_cnt_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic          timeout_q,  timeout_d;
  logic          core_rst_q, core_rst_d;
  logic          core_en_q,  core_en_d;
  logic          done_q,     done_d;

  // Next-state, counter and output decode; outputs are decoded from the
  // next state so the registered copies always match the registered state.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;

    case (state_q)
      IDLE: begin
        if (bus.req) begin
          state_d   = RESET_CORE;
          cnt_d     = '0;
          timeout_d = 1'b0;
          rst_cnt_d = RST_LOAD;
        end
      end
      RESET_CORE: begin
        if (rst_cnt_q == '0) begin
          state_d = RUN;
        end else begin
          rst_cnt_d = rst_cnt_q - 4'd1;
        end
      end
      RUN: begin
        // Halt wins over the limit; the count saturates rather than wraps.
        if (bus.core_halt) begin
          state_d = DONE;
        end else if (cnt_q == MAX_CYC) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (!bus.req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    core_rst_d = (state_d == IDLE) || (state_d == RESET_CORE);
    core_en_d  = (state_d == RUN);
    done_d     = (state_d == DONE);
  end

  // State, counters and registered outputs; reset abandons any run.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rst_cnt_q  <= '0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
      core_rst_q <= 1'b1;
      core_en_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
      core_rst_q <= core_rst_d;
      core_en_q  <= core_en_d;
      done_q     <= done_d;
    end
  end

  assign bus.core_rst    = core_rst_q;
  assign bus.core_en     = core_en_q;
  assign bus.done        = done_q;
  assign bus.timeout     = timeout_q;
  assign bus.cycle_count = cnt_q;
  assign bus.state       = state_q;

endmodule
